// File: rtl/regfile_reader.sv
// Sequential dump engine for the register file: walks readnum over [first..last] (wrapping)
// and streams each word out over valid/ready. Define CLEAR_ON_READ_EN for destructive dumps.
module regfile_reader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] readnum,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              busy,
    output logic              done,
    output logic              write,
    output logic [ADDR_W-1:0] writenum,
    output logic [DATA_W-1:0] wr_data
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StHold,
        StClear,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] IdxOne = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            last_q     <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = first;
                    last_d  = last;
                    state_d = StRead;
                end
            end
            StRead: begin
                out_data_d = rf_data;
                out_idx_d  = idx_q;
                state_d    = StHold;
            end
            StHold: begin
                if (out_ready) begin
`ifdef CLEAR_ON_READ_EN
                    state_d = StClear;
`else
                    if (idx_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IdxOne;
                        state_d = StRead;
                    end
`endif
                end
            end
`ifdef CLEAR_ON_READ_EN
            StClear: begin
                if (idx_q == last_q) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxOne;
                    state_d = StRead;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // idx_q already holds first/next index one cycle before READ, so readnum is settled in READ.
    always_comb begin
        readnum   = idx_q;
        out_data  = out_data_q;
        out_idx   = out_idx_q;
        out_valid = (state_q == StHold);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        wr_data   = '0;
`ifdef CLEAR_ON_READ_EN
        write     = (state_q == StClear);
        writenum  = (state_q == StClear) ? idx_q : '0;
`else
        write     = 1'b0;
        writenum  = '0;
`endif
    end

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: bench-owned register file, expected-word queue model and
// directed dump scenarios.
module tb_regfile_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  first;
    logic [2:0]  last;
    logic [2:0]  readnum;
    logic [15:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_idx;
    logic        busy;
    logic        done;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] wr_data;

    regfile_reader #(
        .DATA_W(16),
        .ADDR_W(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .first    (first),
        .last     (last),
        .readnum  (readnum),
        .rf_data  (rf_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done),
        .write    (write),
        .writenum (writenum),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rf [8];
    assign rf_data = rf[readnum];
    always @(posedge clk) begin
        if (write) rf[writenum] <= wr_data;
    end

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
    } word_t;

    word_t       q[$];
    logic [15:0] exp_mem [8];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          words_rx = 0;
    int          dones_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) begin
            rf[i]      = 16'h1000 + 16'(i);
            exp_mem[i] = 16'h1000 + 16'(i);
        end
    endtask

    // Model: the ordered list of words a dump of [f..l] must deliver.
    task automatic push_expected(input logic [2:0] f, input logic [2:0] l);
        int    n;
        word_t w;
        n = ((int'(l) - int'(f) + 8) % 8) + 1;
        for (int k = 0; k < n; k++) begin
            w.idx  = 3'((int'(f) + k) % 8);
            w.data = exp_mem[w.idx];
            q.push_back(w);
`ifdef CLEAR_ON_READ_EN
            exp_mem[w.idx] = 16'h0000;
`endif
        end
    endtask

    // Compare process: every valid word must match the queue head; accepts pop it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_word", 32'(out_valid), 32'd0);
                end else begin
                    check("word_idx", 32'(out_idx), 32'(q[0].idx));
                    check("word_data", 32'(out_data), 32'(q[0].data));
                    if (out_ready) begin
                        void'(q.pop_front());
                        words_rx++;
                    end
                end
            end
            if (done) begin
                dones_seen++;
                check("done_queue_empty", 32'(q.size()), 32'd0);
            end
            check("wr_data_zero", 32'(wr_data), 32'd0);
`ifndef CLEAR_ON_READ_EN
            check("write_tied", {28'd0, write, writenum}, 32'd0);
`endif
        end
    end

    task automatic start_dump(input logic [2:0] f, input logic [2:0] l);
        push_expected(f, l);
        first = f;
        last  = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        first = ~f;
        last  = ~l;
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_lat1", 32'(out_valid), 32'd0);
        tick();
        check("valid_lat2", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_done(input bit start_in_done);
        int d0;
        bit got;
        d0  = dones_seen;
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            tick();
            if (done) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("busy_in_done", 32'(busy), 32'd1);
            if (start_in_done) start = 1'b1;
            tick();
            start = 1'b0;
            check("busy_after_done", 32'(busy), 32'd0);
            check("done_one_cycle", 32'(done), 32'd0);
            tick();
            check("idle_stays", 32'(busy), 32'd0);
            check("done_count", 32'(dones_seen - d0), 32'd1);
            check("queue_drained", 32'(q.size()), 32'd0);
        end
    endtask

    initial begin
        int w0;
        int d0;
        bit hit;
        rst_n     = 1'b0;
        start     = 1'b0;
        first     = 3'd0;
        last      = 3'd0;
        out_ready = 1'b1;
        preload();
        tick();
        tick();
        check("rst_outs", {busy, done, out_valid, write, readnum, out_idx, out_data}, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Full 0..7 dump.
        w0 = words_rx;
        start_dump(3'd0, 3'd7);
        check("t1_first_data", 32'(out_data), 32'h1000);
        check("t1_first_idx", 32'(out_idx), 32'd0);
        wait_done(1'b0);
        check("t1_words", 32'(words_rx - w0), 32'd8);

        // Wrapping range 6..1, start pulsed during DONE.
        preload();
        w0 = words_rx;
        start_dump(3'd6, 3'd1);
        check("t2_first_data", 32'(out_data), 32'h1006);
        wait_done(1'b1);
        check("t2_words", 32'(words_rx - w0), 32'd4);

        // Single word with back-pressure.
        preload();
        out_ready = 1'b0;
        start_dump(3'd3, 3'd3);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data", 32'(out_data), 32'h1003);
            check("t3_hold_idx", 32'(out_idx), 32'd3);
            tick();
        end
        out_ready = 1'b1;
        check("t3_still_valid", 32'(out_valid), 32'd1);
        wait_done(1'b0);

        // Start re-pulsed after the first accept.
        preload();
        w0 = words_rx;
        start_dump(3'd0, 3'd7);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0);
        check("t4_words", 32'(words_rx - w0), 32'd8);

        // Reset while holding idx 4.
        preload();
        d0 = dones_seen;
        start_dump(3'd0, 3'd7);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (out_valid && out_idx == 3'd4) hit = 1'b1;
            else tick();
        end
        check("t5_reached_idx4", 32'(hit), 32'd1);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_outs", {busy, done, out_valid, write, readnum, out_idx, out_data}, 32'd0);
        q.delete();
        tick();
        tick();
        check("t5_no_done", 32'(dones_seen - d0), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        w0 = words_rx;
        start_dump(3'd0, 3'd1);
        wait_done(1'b0);
        check("t5_words", 32'(words_rx - w0), 32'd2);

`ifdef CLEAR_ON_READ_EN
        // Destructive dump of R2..R3, then a second dump reads zeros.
        preload();
        start_dump(3'd2, 3'd3);
        check("t6_r2_data", 32'(out_data), 32'h1002);
        wait_done(1'b0);
        start_dump(3'd2, 3'd3);
        check("t6_r2_cleared", 32'(out_data), 32'h0000);
        wait_done(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 3) check("t6_cleared", 32'(rf[i]), 32'd0);
            else check("t6_untouched", 32'(rf[i]), 32'h1000 + i);
        end
`else
        for (int i = 0; i < 8; i++) check("rf_untouched", 32'(rf[i]), 32'h1000 + i);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
